hex_ascii_serializer: RTL and testbench
=======================================

Name: hex_ascii_serializer

Overview:
Transmit-side counterpart of the ASCII-hex receive decoder. Latches a binary word and emits it as a stream of ASCII hexadecimal characters, most-significant nibble first, with an optional CR/LF terminator. Sits between the register/readback logic and the UART transmitter. Presents one byte at a time on a valid/ready handshake.

Parameters:
NIBBLES, 4, number of hex digits per word; legal range 1..16; DATA width = 4*NIBBLES
UPPER_CASE, 1, 1: digits A-F encode as 0x41-0x46; 0: encode as 0x61-0x66
APPEND_CRLF, 1, 1: append 0x0D then 0x0A after the last digit; 0: no terminator

Ports:
CLK  input  1  system clock; all logic rising-edge
RST_N  input  1  synchronous active-low reset
DATA  input  4*NIBBLES  word to transmit; sampled only on an accepted START
START  input  1  request; accepted only when BUSY=0
BUSY  output  1  high from the cycle after START is accepted until DONE is issued
CHAR  output  8  ASCII byte offered to the UART transmitter
CHAR_VLD  output  1  CHAR is valid
CHAR_RDY  input  1  transmitter accepts CHAR when CHAR_VLD&CHAR_RDY
DONE  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (RST_N=0 at a clock edge), including mid-word: state=IDLE, BUSY=0, CHAR_VLD=0, CHAR=0x00, DONE=0, shift register and counters cleared. Any partially sent word is abandoned; no DONE is issued.
- States: IDLE, DIGIT, CR, LF, FIN.
- IDLE:
  - START=1 latches DATA into the shift register and loads the digit counter with NIBBLES-1.
  - Next state is DIGIT. BUSY and CHAR_VLD rise on the next cycle.
  - Latency: START edge to first valid CHAR is 1 cycle.
- DIGIT:
  - CHAR = encode(top nibble of the shift register); CHAR_VLD=1.
  - On handshake: shift left by 4 and decrement the counter.
  - On the handshake with counter=0: go to CR if APPEND_CRLF, else FIN.
- CR: CHAR=0x0D, CHAR_VLD=1. On handshake, go to LF.
- LF: CHAR=0x0A, CHAR_VLD=1. On handshake, go to FIN.
- FIN:
  - CHAR_VLD=0, DONE=1 for exactly one cycle, BUSY=1.
  - Next state is IDLE, where BUSY=0.
  - A START in the FIN cycle is ignored. A START in the following IDLE cycle is accepted, so back-to-back words are separated by one idle cycle minimum.
- Handshake rules:
  - While CHAR_VLD=1 and CHAR_RDY=0, CHAR and CHAR_VLD hold stable indefinitely.
  - CHAR_VLD never depends combinationally on CHAR_RDY.
  - Sustained throughput with CHAR_RDY held high is 1 byte per cycle.
- START while BUSY=1 is ignored. DATA changes while BUSY=1 have no effect.
- CHAR and CHAR_VLD are registered outputs, with no combinational path from any input.
- Encoding:
  - Nibble 0-9 maps to 0x30-0x39.
  - Nibble 10-15 maps to 0x41-0x46 (UPPER_CASE=1) or 0x61-0x66 (UPPER_CASE=0).
  - Every code emitted is a legal input to the receive-side decoder, so decode(encode(n)) == n with the valid flag set.
- Digit counter width: $clog2(NIBBLES) with a minimum of 1 bit. NIBBLES=1 emits a single digit.

Decomposition:
- Shared package uart_ascii_pkg holds:
  - ASCII constants: ASCII_0=0x30, ASCII_UC_A=0x41, ASCII_LC_A=0x61, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - State enum: IDLE, DIGIT, CR, LF, FIN.
- One natural sub-module: hex_nibble_to_ascii. Purely combinational, with a 4-bit nibble in, an 8-bit code out and the UPPER_CASE parameter. It is reused by other readback paths.

Test Plan:
- Basic word: DATA=0x1A2F, START pulse, CHAR_RDY=1 -> CHAR sequence 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A on consecutive cycles. DONE one cycle after 0x0A is accepted; BUSY drops the cycle after that.
- Lower case: UPPER_CASE=0, APPEND_CRLF=0, DATA=0xBEEF -> 0x62, 0x65, 0x65, 0x66, then DONE; no 0x0D/0x0A emitted.
- Backpressure: DATA=0x00FF, CHAR_RDY random with 30% high -> CHAR/CHAR_VLD stable during every stall; byte order 0x30, 0x30, 0x46, 0x46, 0x0D, 0x0A; exactly 6 handshakes.
- Ignored START: a second START with DATA=0x1234 mid-word -> the first word completes unchanged and exactly one DONE is issued.
- Reset mid-word: assert RST_N=0 after the 2nd byte -> the next cycle shows CHAR_VLD=0, BUSY=0, DONE=0; a new START of 0x0001 emits 0x30, 0x30, 0x30, 0x31, 0x0D, 0x0A.
- Loopback: all 16 nibble values through this block into the receive decoder -> recovered nibble equals the source and the valid flag is 1 for every digit byte.

Source files
------------

// File: rtl/uart_ascii_pkg.sv
// Shared ASCII constants, serializer state encoding and the hex-digit encoder
// used by the UART readback paths.
package uart_ascii_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIGIT = 3'd1,
    CR    = 3'd2,
    LF    = 3'd3,
    FIN   = 3'd4
  } ser_state_e;

  // Every code produced here must decode back to the same nibble on the receive side.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic upper);
    logic [7:0] code;
    if (nibble < 4'd10) begin
      code = ASCII_0 + {4'h0, nibble};
    end else if (upper) begin
      code = ASCII_UC_A + {4'h0, nibble - 4'd10};
    end else begin
      code = ASCII_LC_A + {4'h0, nibble - 4'd10};
    end
    return code;
  endfunction

endpackage

// File: rtl/hex_ascii_serializer_enc.sv
// Combinational nibble-to-ASCII hex encoder, shared with other readback paths.
module hex_nibble_to_ascii
  import uart_ascii_pkg::*;
#(
  parameter bit UPPER_CASE = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] code
);

  assign code = nibble_to_ascii(nibble, UPPER_CASE);

endmodule

// File: rtl/hex_ascii_serializer.sv
// Serializes a latched binary word as ASCII hex characters (MSB nibble first),
// optionally followed by CR/LF, over a valid/ready byte handshake.
module hex_ascii_serializer
  import uart_ascii_pkg::*;
#(
  parameter int NIBBLES     = 4,
  parameter bit UPPER_CASE  = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [4*NIBBLES-1:0]   DATA,
  input  logic                   START,
  output logic                   BUSY,
  output logic [7:0]             CHAR,
  output logic                   CHAR_VLD,
  input  logic                   CHAR_RDY,
  output logic                   DONE
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NIBBLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  ser_state_e    state_r;
  ser_state_e    state_s;
  logic [W-1:0]  shift_r;
  logic [W-1:0]  shift_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [7:0]    char_r;
  logic [7:0]    char_s;
  logic          vld_r;
  logic          vld_s;
  logic          busy_r;
  logic          busy_s;
  logic          done_r;
  logic          done_s;
  logic [7:0]    top_code_s;
  logic          handshake_s;

  assign handshake_s = vld_r & CHAR_RDY;

  // Outputs are registered from the next-state view, so the encoder looks at
  // the next shift-register contents.
  hex_nibble_to_ascii #(
    .UPPER_CASE(UPPER_CASE)
  ) u_enc (
    .nibble(shift_s[W-1 -: 4]),
    .code  (top_code_s)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (START) begin
          state_s = DIGIT;
          shift_s = DATA;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      DIGIT: begin
        if (handshake_s) begin
          shift_s = shift_r << 3'd4;
          cnt_s   = cnt_r - CNT_ONE;
          if (cnt_r != CNT_ZERO) begin
            state_s = DIGIT;
          end else if (APPEND_CRLF) begin
            state_s = CR;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = DIGIT;
        end
      end
      CR: begin
        if (handshake_s) begin
          state_s = LF;
        end else begin
          state_s = CR;
        end
      end
      LF: begin
        if (handshake_s) begin
          state_s = FIN;
        end else begin
          state_s = LF;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values the registers will present in the next state.
  always_comb begin
    char_s = 8'h00;
    vld_s  = 1'b0;
    busy_s = 1'b1;
    done_s = 1'b0;
    case (state_s)
      IDLE:  busy_s = 1'b0;
      DIGIT: begin
        char_s = top_code_s;
        vld_s  = 1'b1;
      end
      CR: begin
        char_s = ASCII_CR;
        vld_s  = 1'b1;
      end
      LF: begin
        char_s = ASCII_LF;
        vld_s  = 1'b1;
      end
      FIN:     done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      char_r  <= 8'h00;
      vld_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      char_r  <= char_s;
      vld_r   <= vld_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign CHAR     = char_r;
  assign CHAR_VLD = vld_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Scoreboard bench: three serializer configurations (upper+CRLF, lower/no CRLF,
// single nibble); a negedge monitor compares every accepted byte and DONE.
module tb_hex_ascii_serializer;

  bit          CLK = 1'b0;
  logic        RST_N;
  logic [15:0] dat [3];
  logic        st [3];
  logic [7:0]  ch [3];
  logic        vld [3];
  logic        busy [3];
  logic        done [3];
  logic        rdy [3];
  bit          rdy_rand [3];
  bit          rdy_fix [3];

  logic [7:0]  exp_q [3][$];
  logic [3:0]  nib_q [3][$];
  int          hs_cnt [3];
  int          done_cnt [3];
  int          last_hs [3];
  logic        prev_stall [3];
  logic        prev_done [3];
  logic [7:0]  prev_ch [3];
  int          cyc;
  int          checks;
  int          errors;

  always #5 CLK = ~CLK;

  hex_ascii_serializer #(.NIBBLES(4), .UPPER_CASE(1'b1), .APPEND_CRLF(1'b1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .DATA(dat[0]), .START(st[0]), .BUSY(busy[0]),
    .CHAR(ch[0]), .CHAR_VLD(vld[0]), .CHAR_RDY(rdy[0]), .DONE(done[0]));

  hex_ascii_serializer #(.NIBBLES(4), .UPPER_CASE(1'b0), .APPEND_CRLF(1'b0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .DATA(dat[1]), .START(st[1]), .BUSY(busy[1]),
    .CHAR(ch[1]), .CHAR_VLD(vld[1]), .CHAR_RDY(rdy[1]), .DONE(done[1]));

  hex_ascii_serializer #(.NIBBLES(1), .UPPER_CASE(1'b1), .APPEND_CRLF(1'b0)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .DATA(dat[2][3:0]), .START(st[2]), .BUSY(busy[2]),
    .CHAR(ch[2]), .CHAR_VLD(vld[2]), .CHAR_RDY(rdy[2]), .DONE(done[2]));

  // Receive-side decoder model: {valid, nibble}
  function automatic logic [4:0] dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    else return 5'h00;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0h, expected %0h (cycle %0d)", nm, i, got, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #2;
    for (int i = 0; i < 3; i++) rdy[i] = rdy_rand[i] ? ($urandom_range(0, 9) < 3) : rdy_fix[i];
  end

  // Monitor: pops the scoreboard on every handshake and checks stall/DONE rules.
  always @(negedge CLK) begin
    logic [7:0] b;
    logic [4:0] d;
    for (int i = 0; i < 3; i++) begin
      if (RST_N === 1'b1 && prev_stall[i] === 1'b1) begin
        chk("stall_vld", i, 32'(vld[i]), 32'd1);
        chk("stall_char", i, 32'(ch[i]), 32'(prev_ch[i]));
      end
      if (RST_N === 1'b1 && prev_done[i] === 1'b1) chk("busy_after_done", i, 32'(busy[i]), 32'd0);
      if (RST_N === 1'b1 && vld[i] === 1'b1 && rdy[i] === 1'b1) begin
        hs_cnt[i]++;
        last_hs[i] = cyc;
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte[dut%0d]: got %02h, expected none", i, ch[i]);
        end else begin
          b = exp_q[i].pop_front();
          chk("char", i, 32'(ch[i]), 32'(b));
        end
        if (ch[i] != 8'h0D && ch[i] != 8'h0A) begin
          d = dec(ch[i]);
          chk("dec_valid", i, 32'(d[4]), 32'd1);
          if (nib_q[i].size() != 0) chk("dec_nibble", i, 32'(d[3:0]), 32'(nib_q[i].pop_front()));
        end
      end
      if (RST_N === 1'b1 && done[i] === 1'b1) begin
        done_cnt[i]++;
        chk("done_after_last", i, 32'(last_hs[i]), 32'(cyc - 1));
        chk("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
      end
      prev_stall[i] = vld[i] & ~rdy[i] & RST_N;
      prev_done[i]  = done[i] & RST_N;
      prev_ch[i]    = ch[i];
    end
  end

  task automatic pulse_start(input int i, input logic [15:0] d);
    @(posedge CLK); #1;
    dat[i] = d;
    st[i]  = 1'b1;
    @(posedge CLK); #1;
    st[i]  = 1'b0;
  endtask

  task automatic send(input int i, input logic [15:0] d, input logic [47:0] ex, input int nb);
    int nd;
    nd = (i == 2) ? 1 : 4;
    for (int k = 0; k < nb; k++) exp_q[i].push_back(ex[47-8*k -: 8]);
    for (int k = 0; k < nd; k++) nib_q[i].push_back(d[4*(nd-1-k) +: 4]);
    pulse_start(i, d);
  endtask

  task automatic wait_done(input int i, input int target);
    int n;
    n = 0;
    while (done_cnt[i] < target && n < 300) begin
      @(posedge CLK);
      n++;
    end
    chk("done_count", i, 32'(done_cnt[i]), 32'(target));
  endtask

  initial begin
    int h;
    cyc = 0; checks = 0; errors = 0;
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dat[i] = 16'h0000; st[i] = 1'b0; rdy[i] = 1'b1;
      rdy_fix[i] = 1'b1; rdy_rand[i] = 1'b0;
      hs_cnt[i] = 0; done_cnt[i] = 0; last_hs[i] = -10;
      prev_stall[i] = 1'b0; prev_done[i] = 1'b0; prev_ch[i] = 8'h00;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("rst_char", i, 32'(ch[i]), 32'h00);
      chk("rst_vld", i, 32'(vld[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Basic word, first-byte latency, lower case without CRLF, single-nibble config
    send(0, 16'h1A2F, 48'h3141_3246_0D0A, 6);
    @(negedge CLK);
    chk("latency_vld", 0, 32'(vld[0]), 32'd1);
    chk("latency_busy", 0, 32'(busy[0]), 32'd1);
    wait_done(0, 1);
    send(1, 16'hBEEF, 48'h6265_6566_0000, 4);
    wait_done(1, 1);
    send(1, 16'hA09F, 48'h6130_3966_0000, 4);
    wait_done(1, 2);
    send(2, 16'h0007, 48'h3700_0000_0000, 1);
    wait_done(2, 1);
    send(2, 16'h000E, 48'h4500_0000_0000, 1);
    wait_done(2, 2);

    // Backpressure with ~30% ready
    rdy_rand[0] = 1'b1;
    h = hs_cnt[0];
    send(0, 16'h00FF, 48'h3030_4646_0D0A, 6);
    wait_done(0, 2);
    chk("bp_handshakes", 0, 32'(hs_cnt[0] - h), 32'd6);
    rdy_rand[0] = 1'b0;

    // START while busy is ignored
    send(0, 16'hC0DE, 48'h4330_4445_0D0A, 6);
    pulse_start(0, 16'h1234);
    dat[0] = 16'h0000;
    wait_done(0, 3);
    repeat (5) @(posedge CLK);
    chk("single_done", 0, 32'(done_cnt[0]), 32'd3);

    // Reset after the second byte
    exp_q[0].push_back(8'h31); exp_q[0].push_back(8'h41);
    nib_q[0].push_back(4'h1);  nib_q[0].push_back(4'hA);
    pulse_start(0, 16'h1A2F);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    rdy_fix[0] = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_vld", 0, 32'(vld[0]), 32'd0);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
    chk("midrst_char", 0, 32'(ch[0]), 32'h00);
    chk("midrst_bytes", 0, 32'(exp_q[0].size()), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    rdy_fix[0] = 1'b1;
    repeat (3) @(posedge CLK);
    chk("midrst_no_done", 0, 32'(done_cnt[0]), 32'd3);
    send(0, 16'h0001, 48'h3030_3031_0D0A, 6);
    wait_done(0, 4);

    // Loopback of all 16 nibble values through the decoder model
    send(0, 16'h0123, 48'h3031_3233_0D0A, 6); wait_done(0, 5);
    send(0, 16'h4567, 48'h3435_3637_0D0A, 6); wait_done(0, 6);
    send(0, 16'h89AB, 48'h3839_4142_0D0A, 6); wait_done(0, 7);
    send(0, 16'hCDEF, 48'h4344_4546_0D0A, 6); wait_done(0, 8);
    send(1, 16'hCDA5, 48'h6364_6135_0000, 4); wait_done(1, 3);

    repeat (4) @(posedge CLK);
    for (int i = 0; i < 3; i++) chk("final_empty", i, 32'(exp_q[i].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
